// File: rtl/bitty_pkg.sv
// bitty_pkg: shared states, instruction field positions and branch decode for the Bitty sequencer
package bitty_pkg;
    typedef enum logic [3:0] {
        IDLE, FETCH, ISSUE, LOAD, EXEC, WB, ADVANCE, HALTED, ERROR
    } state_t;
    localparam logic [1:0] FMT_ALU_R   = 2'b00;
    localparam logic [1:0] FMT_ALU_I   = 2'b01;
    localparam logic [1:0] FMT_BRANCH  = 2'b10;
    localparam logic [1:0] FMT_HALT    = 2'b11;
    localparam logic [1:0] COND_ALWAYS  = 2'b00;
    localparam logic [1:0] COND_ZERO    = 2'b01;
    localparam logic [1:0] COND_NONZERO = 2'b10;
    localparam logic [1:0] COND_NEVER   = 2'b11;
    localparam int RX_HI   = 15;
    localparam int RX_LO   = 13;
    localparam int RY_HI   = 12;
    localparam int RY_LO   = 10;
    localparam int FMT_HI  = 1;
    localparam int FMT_LO  = 0;
    localparam int COND_HI = 3;
    localparam int COND_LO = 2;
    localparam int TGT_HI  = 12;
    localparam int TGT_LO  = 5;
    function automatic logic branch_taken(input logic [1:0] cond, input logic [15:0] res);
        return cond != COND_NEVER && (cond == COND_ALWAYS || ((res == '0) == (cond == COND_ZERO)));
    endfunction
endpackage

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit: imem handshake, instruction capture and fetch timeout detection
module bitty_fetch_unit #(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        active,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic        fetch_done,
    output logic        fetch_timeout,
    output logic [15:0] instruction
);
    localparam int TW = $clog2(FETCH_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   instr_q, instr_d;
    // timeout fires on the last allowed cycle so ERROR is entered exactly FETCH_TIMEOUT cycles in
    always_comb begin
        fetch_done    = active && imem_valid;
        fetch_timeout = active && !imem_valid && tmo_q == TW'(FETCH_TIMEOUT - 1);
        tmo_d         = (active && !imem_valid && !fetch_timeout) ? tmo_q + TW'(1) : '0;
        instr_d       = fetch_done ? imem_data : instr_q;
    end
    // counter and instruction register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q   <= '0;
            instr_q <= '0;
        end else begin
            tmo_q   <= tmo_d;
            instr_q <= instr_d;
        end
    end
    assign instruction = instr_q;
endmodule

// File: rtl/bitty_sequencer.sv
// bitty_sequencer: fetch/issue FSM stepping the Bitty datapath through load, compute and write-back
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int PC_WIDTH      = 8,
    parameter int FETCH_TIMEOUT = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 halt_req,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_valid,
    input  logic [15:0]          imem_data,
    output logic [15:0]          instruction,
    output logic                 en_i,
    output logic                 en_s,
    output logic                 en_c,
    output logic [7:0]           en_reg,
    input  logic [15:0]          last_result,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 fetch_err,
    output logic [CNT_WIDTH-1:0] instr_count
);
    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_q, en_i_q, en_s_q, en_c_q, busy_q, halted_q, err_q;
    logic [7:0]            en_reg_q;
    logic                  fetch_done, fetch_timeout;
    logic [1:0]            fmt;
    bitty_fetch_unit #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_fetch (
        .clk          (clk),
        .reset_n      (reset_n),
        .active       (req_q),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .fetch_done   (fetch_done),
        .fetch_timeout(fetch_timeout),
        .instruction  (instruction)
    );
    assign fmt = instruction[FMT_HI:FMT_LO];
    // next state, branch resolution and retire counting
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = fetch_done ? ISSUE : fetch_timeout ? ERROR : FETCH;
            ISSUE:   state_d = (fmt == FMT_ALU_R || fmt == FMT_ALU_I) ? LOAD :
                               fmt == FMT_BRANCH ? ADVANCE : HALTED;
            LOAD:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = ADVANCE;
            ADVANCE: state_d = halt_req ? HALTED : step_mode ? IDLE : FETCH;
            HALTED:  state_d = start ? FETCH : HALTED;
            default: state_d = ERROR;
        endcase
        pc_d  = state_q != ADVANCE ? pc_q :
                (fmt == FMT_BRANCH && branch_taken(instruction[COND_HI:COND_LO], last_result)) ?
                PC_WIDTH'(instruction[TGT_HI:TGT_LO]) : pc_q + PC_WIDTH'(1);
        cnt_d = (state_q == ADVANCE || (state_q == ISSUE && fmt == FMT_HALT)) ?
                cnt_q + CNT_WIDTH'(1) : cnt_q;
    end
    // state register with outputs registered from the next state so each enable lines up with its phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            en_i_q   <= 1'b0;
            en_s_q   <= 1'b0;
            en_c_q   <= 1'b0;
            en_reg_q <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            req_q    <= state_d == FETCH;
            en_i_q   <= state_d == ISSUE;
            en_s_q   <= state_d == LOAD;
            en_c_q   <= state_d == EXEC;
            en_reg_q <= state_d == WB ? 8'd1 << instruction[RX_HI:RX_LO] : 8'd0;
            busy_q   <= state_d != IDLE && state_d != HALTED;
            halted_q <= state_d == HALTED;
            err_q    <= err_q || fetch_timeout;
        end
    end
    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign en_i        = en_i_q;
    assign en_s        = en_s_q;
    assign en_c        = en_c_q;
    assign en_reg      = en_reg_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign fetch_err   = err_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_bitty_sequencer.sv
// tb_bitty_sequencer: directed table-driven checks of the Bitty sequencer
module tb_bitty_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b1;
    logic        halt_req = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic        en_i, en_s, en_c;
    logic [7:0]  en_reg;
    logic [15:0] last_result = '0;
    logic [7:0]  pc;
    logic        busy, halted, fetch_err;
    logic [15:0] instr_count;

    logic [15:0] mem [256];
    int          resp_dly = 0;
    logic        resp_en = 1'b1;
    int          req_age = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt = '0;

    bitty_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .step_mode(step_mode), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .instruction(instruction), .en_i(en_i), .en_s(en_s), .en_c(en_c), .en_reg(en_reg),
        .last_result(last_result), .pc(pc), .busy(busy), .halted(halted), .fetch_err(fetch_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assign imem_valid = imem_req && resp_en && (req_age >= resp_dly);
    assign imem_data  = mem[imem_addr];
    always @(posedge clk) req_age <= (imem_req && !imem_valid) ? req_age + 1 : 0;

    typedef struct {
        logic [7:0]  pc0;
        logic [15:0] word;
        logic [15:0] lr;
        int          dly;
        logic        step;
        logic        hreq;
        logic [7:0]  exp_pc;
        int          exp_n;
        logic [63:0] exp_tr;
        logic [7:0]  exp_en;
        logic        exp_halt;
        int          ret;
    } vec_t;
    vec_t tab [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int          n;
        int          k;
        logic [63:0] tr;
        logic [7:0]  en;
        logic [3:0]  code;
        mem[v.pc0] = v.word;
        last_result = v.lr;
        resp_dly = v.dly;
        step_mode = v.step;
        halt_req = v.hreq;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("row%0d_fetch_addr", idx), imem_addr, v.pc0);
        chk($sformatf("row%0d_fetch_req", idx), imem_req, 1);
        n = 0;
        tr = '0;
        en = '0;
        while (busy && n < 40) begin
            k = int'(en_i) + int'(en_s) + int'(en_c) + int'(en_reg != 0);
            code = (k > 1 || (en_reg != 0 && !$onehot(en_reg))) ? 4'hF :
                   en_i ? 4'h1 : en_s ? 4'h2 : en_c ? 4'h3 : en_reg != 0 ? 4'h4 : 4'h0;
            tr = {tr[59:0], code};
            if (en_reg != 0) en = en_reg;
            n++;
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 16'(v.ret);
        chk($sformatf("row%0d_cycles", idx), 64'(n), 64'(v.exp_n));
        chk($sformatf("row%0d_enable_trace", idx), tr, v.exp_tr);
        chk($sformatf("row%0d_en_reg", idx), en, v.exp_en);
        chk($sformatf("row%0d_pc", idx), pc, v.exp_pc);
        chk($sformatf("row%0d_halted", idx), halted, v.exp_halt);
        chk($sformatf("row%0d_instr_count", idx), instr_count, exp_cnt);
        halt_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
    endtask

    initial begin
        int   n;
        logic bad;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0003;
        //            pc0    word      lr        dly step hreq exp_pc n   trace                en     halt ret
        tab[0]  = '{8'h00, 16'h2001, 16'h0000, 0, 1'b1, 1'b0, 8'h01, 6, 64'h012340,         8'h02, 1'b0, 1};
        tab[1]  = '{8'h01, 16'h0806, 16'h0000, 0, 1'b1, 1'b0, 8'h40, 3, 64'h010,            8'h00, 1'b0, 1};
        tab[2]  = '{8'h40, 16'h0806, 16'h0005, 0, 1'b1, 1'b0, 8'h41, 3, 64'h010,            8'h00, 1'b0, 1};
        tab[3]  = '{8'h41, 16'h020A, 16'h0005, 0, 1'b1, 1'b0, 8'h10, 3, 64'h010,            8'h00, 1'b0, 1};
        tab[4]  = '{8'h10, 16'h020A, 16'h0000, 0, 1'b1, 1'b0, 8'h11, 3, 64'h010,            8'h00, 1'b0, 1};
        tab[5]  = '{8'h11, 16'h100E, 16'h0000, 0, 1'b1, 1'b0, 8'h12, 3, 64'h010,            8'h00, 1'b0, 1};
        tab[6]  = '{8'h12, 16'h1FE2, 16'h0000, 0, 1'b1, 1'b0, 8'hFF, 3, 64'h010,            8'h00, 1'b0, 1};
        tab[7]  = '{8'hFF, 16'hE000, 16'h0000, 0, 1'b1, 1'b0, 8'h00, 6, 64'h012340,         8'h80, 1'b0, 1};
        tab[8]  = '{8'h00, 16'h0C00, 16'h0000, 0, 1'b1, 1'b0, 8'h01, 6, 64'h012340,         8'h01, 1'b0, 1};
        tab[9]  = '{8'h01, 16'h2001, 16'h0000, 1, 1'b1, 1'b0, 8'h02, 7, 64'h0012340,        8'h02, 1'b0, 1};
        tab[10] = '{8'h02, 16'h0003, 16'h0000, 0, 1'b1, 1'b0, 8'h02, 2, 64'h01,             8'h00, 1'b1, 1};
        tab[11] = '{8'h02, 16'h0003, 16'h0000, 0, 1'b1, 1'b0, 8'h02, 2, 64'h01,             8'h00, 1'b1, 1};
        tab[12] = '{8'h00, 16'h2001, 16'h0000, 0, 1'b1, 1'b1, 8'h01, 6, 64'h012340,         8'h02, 1'b1, 1};
        tab[13] = '{8'h01, 16'h2001, 16'h0000, 0, 1'b0, 1'b0, 8'h05, 11, 64'h01234001001,   8'h02, 1'b1, 3};

        repeat (2) @(negedge clk);
        chk("reset_pc", pc, 0);
        chk("reset_instruction", instruction, 0);
        chk("reset_count", instr_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_halted", halted, 0);
        chk("reset_fetch_err", fetch_err, 0);
        chk("reset_enables", {imem_req, en_i, en_s, en_c, en_reg}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_row(i, tab[i]);
        chk("halted_not_busy", busy, 0);

        do_reset();
        mem[0] = 16'h2001;
        step_mode = 1'b1;
        resp_dly = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!en_c && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("exec_reached", en_c, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_instruction", instruction, 0);
        chk("async_rst_enables", {imem_req, en_i, en_s, en_c, en_reg}, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_pc", pc, 0);
        chk("async_rst_count", instr_count, 0);
        bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (en_reg != 0) bad = 1'b1;
        end
        reset_n = 1'b1;
        exp_cnt = '0;
        repeat (5) begin
            @(negedge clk);
            if (en_reg != 0 || busy) bad = 1'b1;
        end
        chk("no_wb_after_reset", bad, 0);

        mem[2] = 16'h00A2;
        mem[5] = 16'h0003;
        for (int i = 12; i < 14; i++) run_row(i, tab[i]);

        do_reset();
        resp_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        bad = 1'b0;
        while (!fetch_err && n < 40) begin
            if (en_i || en_s || en_c || en_reg != 0) bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", 64'(n), 16);
        chk("timeout_quiet_enables", bad, 0);
        chk("error_busy", busy, 1);
        chk("error_no_req", imem_req, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("error_sticky", fetch_err, 1);
        chk("error_ignores_start", {imem_req, en_i, en_s, en_c, en_reg}, 0);
        reset_n = 1'b0;
        #1;
        chk("error_cleared_by_reset", fetch_err, 0);
        resp_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
